// File: rtl/gray_to_bin_seq_if.sv
// Handshake bundle for gray_to_bin_seq.
//   in_valid/in_ready/gray_in    : Gray word input handshake
//   out_valid/out_ready/bin_out  : decoded binary result handshake
//   busy                         : decoder is resolving bits
//   seq_err                      : Gray sequence violation pulse (GRAY_SEQ_CHECK_EN only)
// Modports: master drives words in and accepts results; slave is the decoder.
// Optional feature macro: GRAY_SEQ_CHECK_EN (adds seq_err).
interface gray_to_bin_seq_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] gray_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] bin_out;
  logic             busy;
`ifdef GRAY_SEQ_CHECK_EN
  logic             seq_err;

  modport master (
    output in_valid, gray_in, out_ready,
    input  in_ready, out_valid, bin_out, busy, seq_err
  );

  modport slave (
    input  in_valid, gray_in, out_ready,
    output in_ready, out_valid, bin_out, busy, seq_err
  );
`else
  modport master (
    output in_valid, gray_in, out_ready,
    input  in_ready, out_valid, bin_out, busy
  );

  modport slave (
    input  in_valid, gray_in, out_ready,
    output in_ready, out_valid, bin_out, busy
  );
`endif
endinterface

// File: rtl/gray_to_bin_seq.sv
// Sequential Gray-to-binary decoder: captures one Gray word, resolves one bit
// per clock MSB-first, then holds the binary result until it is taken.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : gray_to_bin_seq_if.slave (in_valid/in_ready/gray_in,
//           out_valid/out_ready/bin_out, busy, seq_err)
// Parameter WIDTH: code word width, 2..16.
// Optional feature macro: GRAY_SEQ_CHECK_EN -- tracks the last accepted word
// and pulses seq_err when consecutive accepted words are not Hamming distance 1.
module gray_to_bin_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  gray_to_bin_seq_if.slave   bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > 16) begin : g_width_check
    $error("gray_to_bin_seq: WIDTH must be in 2..16");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] gray_q, gray_d;     // captured word, immune to later gray_in changes
  logic [WIDTH-1:0] work_q, work_d;     // bits resolved so far
  logic             par_q, par_d;       // previously resolved bit b[cnt+1]
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic             in_ready_c;
  logic             accept_c;
  logic             bit_c;

`ifdef GRAY_SEQ_CHECK_EN
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             have_prev_q, have_prev_d;
  logic             seq_err_q, seq_err_d;

  // True when a and b differ in exactly one bit position.
  function automatic logic dist_is_one(input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] diff;
    diff = a ^ b;
    return (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
  endfunction
`endif

  // Ready is combinational so a HOLD result and a new word can swap on one edge.
  always_comb begin
    in_ready_c = 1'b0;
    case (state_q)
      IDLE:    in_ready_c = 1'b1;
      HOLD:    in_ready_c = bus.out_ready;
      default: in_ready_c = 1'b0;
    endcase
  end

  assign accept_c = bus.in_valid && in_ready_c;
  assign bit_c    = par_q ^ gray_q[cnt_q];

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gray_d      = gray_q;
    work_d      = work_q;
    par_d       = par_q;
    bin_d       = bin_q;
    out_valid_d = out_valid_q;
`ifdef GRAY_SEQ_CHECK_EN
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    seq_err_d   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      DECODE: begin
        work_d[cnt_q] = bit_c;
        par_d         = bit_c;
        if (cnt_q == '0) begin
          bin_d       = work_q;
          bin_d[0]    = bit_c;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Accept overrides IDLE/HOLD defaults; only possible from those states.
    if (accept_c) begin
      gray_d  = bus.gray_in;
      cnt_d   = CNT_TOP;
      work_d  = '0;
      par_d   = 1'b0;
      state_d = DECODE;
`ifdef GRAY_SEQ_CHECK_EN
      seq_err_d   = have_prev_q && !dist_is_one(bus.gray_in, prev_q);
      prev_d      = bus.gray_in;
      have_prev_d = 1'b1;
`endif
    end

    busy_d = (state_d == DECODE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gray_q      <= '0;
      work_q      <= '0;
      par_q       <= 1'b0;
      bin_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef GRAY_SEQ_CHECK_EN
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      seq_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gray_q      <= gray_d;
      work_q      <= work_d;
      par_q       <= par_d;
      bin_q       <= bin_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef GRAY_SEQ_CHECK_EN
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      seq_err_q   <= seq_err_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.bin_out   = bin_q;
  assign bus.busy      = busy_q;
`ifdef GRAY_SEQ_CHECK_EN
  assign bus.seq_err   = seq_err_q;
`endif

endmodule

// File: tb/tb_gray_to_bin_seq.sv
// Self-checking bench for gray_to_bin_seq (WIDTH=4): directed scenarios plus
// randomized words and stalls, checked against a Gray inverse table built from
// the forward encoding g = b ^ (b >> 1).
module tb_gray_to_bin_seq;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned NCODES = 1 << WIDTH;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  gray_to_bin_seq_if #(.WIDTH(WIDTH)) bus ();

  gray_to_bin_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned      n_checks;
  int unsigned      n_fails;
  logic [WIDTH-1:0] inv_tab [NCODES];
  logic [WIDTH-1:0] last_bin;

`ifdef GRAY_SEQ_CHECK_EN
  logic             have_prev;
  logic [WIDTH-1:0] prev_word;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks right after an accepting edge; updates the sequence model.
  task automatic note_accept(input logic [WIDTH-1:0] g);
`ifdef GRAY_SEQ_CHECK_EN
    int d;
`endif
    check("acc_busy", 32'(bus.busy), 1);
    check("acc_in_ready", 32'(bus.in_ready), 0);
    check("acc_out_valid", 32'(bus.out_valid), 0);
`ifdef GRAY_SEQ_CHECK_EN
    d = 0;
    for (int i = 0; i < int'(WIDTH); i++) if (g[i] != prev_word[i]) d++;
    check("seq_err", 32'(bus.seq_err), 32'(have_prev && (d != 1)));
    have_prev = 1'b1;
    prev_word = g;
`endif
  endtask

  // Clock until out_valid, scrambling ignored inputs; checks latency and result.
  task automatic wait_result(input logic [WIDTH-1:0] g);
    int lat;
    lat = 0;
    while (lat < int'(4 * WIDTH)) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.gray_in  = WIDTH'($urandom);
      step();
      lat++;
      if (bus.out_valid) break;
      check("decode_bin_hold", 32'(bus.bin_out), 32'(last_bin));
`ifdef GRAY_SEQ_CHECK_EN
      check("seq_err_pulse_width", 32'(bus.seq_err), 0);
`endif
    end
    bus.in_valid = 1'b0;
    check("latency", 32'(lat), WIDTH);
    check("bin_out", 32'(bus.bin_out), 32'(inv_tab[g]));
    check("result_busy", 32'(bus.busy), 0);
    last_bin = inv_tab[g];
  endtask

  // Full transaction from IDLE with a downstream stall of 'stall' cycles.
  task automatic send(input logic [WIDTH-1:0] g, input int stall);
    check("idle_in_ready", 32'(bus.in_ready), 1);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.gray_in   = g;
    step();
    note_accept(g);
    wait_result(g);
    repeat (stall) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      step();
      check("stall_valid", 32'(bus.out_valid), 1);
      check("stall_bin", 32'(bus.bin_out), 32'(inv_tab[g]));
      check("stall_in_ready", 32'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("hold_in_ready", 32'(bus.in_ready), 1);
    step();
    check("drain_valid", 32'(bus.out_valid), 0);
    check("drain_bin_kept", 32'(bus.bin_out), 32'(inv_tab[g]));
    bus.out_ready = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_bin_out"}, 32'(bus.bin_out), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 1);
`ifdef GRAY_SEQ_CHECK_EN
    check({tag, "_seq_err"}, 32'(bus.seq_err), 0);
`endif
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("reset");
    last_bin = '0;
`ifdef GRAY_SEQ_CHECK_EN
    have_prev = 1'b0;
    prev_word = '0;
`endif
    repeat (2) begin
      step();
      check("in_reset_valid", 32'(bus.out_valid), 0);
    end
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] bb;
    logic [WIDTH-1:0] g;
    n_checks = 0;
    n_fails  = 0;
    last_bin = '0;
`ifdef GRAY_SEQ_CHECK_EN
    have_prev = 1'b0;
    prev_word = '0;
`endif
    for (int b = 0; b < int'(NCODES); b++) begin
      bb = WIDTH'(b);
      inv_tab[bb ^ (bb >> 1)] = bb;
    end

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.gray_in   = '0;
    bus.out_ready = 1'b0;
    repeat (2) step();
    check_reset_values("por");

    // First accept on the first edge after release; 1000 -> 1111 with out_ready=1.
    #2 rst_n = 1'b1;
    bus.in_valid  = 1'b1;
    bus.gray_in   = WIDTH'(4'b1000);
    bus.out_ready = 1'b1;
    step();
    note_accept(WIDTH'(4'b1000));
    wait_result(WIDTH'(4'b1000));
    check("req030_bin", 32'(bus.bin_out), 32'(4'b1111));
    step();
    check("req030_drain", 32'(bus.out_valid), 0);
    check("req030_idle", 32'(bus.in_ready), 1);
    bus.out_ready = 1'b0;

    // All 16 codes back-to-back with in_valid and out_ready held high.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.gray_in   = '0;
    step();
    note_accept('0);
    for (int k = 0; k < int'(NCODES); k++) begin
      for (int c = 1; c <= int'(WIDTH); c++) begin
        bus.gray_in = WIDTH'($urandom);
        step();
        if (c < int'(WIDTH)) check("b2b_early_valid", 32'(bus.out_valid), 0);
      end
      check("b2b_valid", 32'(bus.out_valid), 1);
      check("b2b_bin", 32'(bus.bin_out), 32'(inv_tab[k]));
      check("b2b_in_ready", 32'(bus.in_ready), 1);
      last_bin = inv_tab[k];
      if (k < int'(NCODES) - 1) begin
        bus.gray_in = WIDTH'(k + 1);
        step();
        note_accept(WIDTH'(k + 1));
      end else begin
        bus.in_valid = 1'b0;
        step();
        check("b2b_end_valid", 32'(bus.out_valid), 0);
        check("b2b_end_idle", 32'(bus.in_ready), 1);
      end
    end
    bus.out_ready = 1'b0;
    check("inv_0110", 32'(inv_tab[6]), 32'(4'b0100));
    check("inv_1010", 32'(inv_tab[10]), 32'(4'b1100));

    // Long downstream stall: 0011 -> 0010 held for 10 cycles.
    send(WIDTH'(4'b0011), 10);
    check("req032_bin", 32'(bus.bin_out), 32'(4'b0010));

    // Reset two edges after accepting 1111: word discarded.
    bus.in_valid = 1'b1;
    bus.gray_in  = WIDTH'(4'b1111);
    step();
    note_accept(WIDTH'(4'b1111));
    bus.in_valid = 1'b0;
    repeat (2) step();
    apply_reset();
    check_reset_values("post_release");
    repeat (6) begin
      step();
      check("no_result_after_reset", 32'(bus.out_valid), 0);
      check("idle_after_reset", 32'(bus.in_ready), 1);
    end

    // Same-edge handoff: HOLD with out_ready=1, in_valid=1 carrying 0101.
    bus.in_valid = 1'b1;
    bus.gray_in  = WIDTH'(4'b0001);
    step();
    note_accept(WIDTH'(4'b0001));
    wait_result(WIDTH'(4'b0001));
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.gray_in   = WIDTH'(4'b0101);
    step();
    note_accept(WIDTH'(4'b0101));
    bus.out_ready = 1'b0;
    wait_result(WIDTH'(4'b0101));
    check("req034_bin", 32'(bus.bin_out), 32'(4'b0110));
    bus.out_ready = 1'b1;
    step();
    check("req034_drain", 32'(bus.out_valid), 0);
    bus.out_ready = 1'b0;

    // Randomized words and stalls.
    for (int n = 0; n < 40; n++) begin
      g = WIDTH'($urandom);
      send(g, int'($urandom_range(0, 3)));
    end

`ifdef GRAY_SEQ_CHECK_EN
    // Sequence checker: 0000, 0001, 0011, 0110, 0110 from a fresh reset.
    apply_reset();
    send(WIDTH'(4'b0000), 0);
    send(WIDTH'(4'b0001), 0);
    send(WIDTH'(4'b0011), 0);
    send(WIDTH'(4'b0110), 0);
    send(WIDTH'(4'b0110), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/gray_to_bin_seq.md
GRAY_TO_BIN_SEQ -- requirements
Module: gray_to_bin_seq

Interface
REQ-001 Parameter: WIDTH, default 4, code word width in bits, legal range 2..16.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  gray_in holds a word to decode.
REQ-005 Port: in_ready  output  1  block can accept a word.
REQ-006 Port: gray_in  input  WIDTH  Gray-coded input word.
REQ-007 Port: out_valid  output  1  bin_out holds a decoded result.
REQ-008 Port: out_ready  input  1  downstream accepts bin_out.
REQ-009 Port: bin_out  output  WIDTH  decoded binary word, registered.
REQ-010 Port: busy  output  1  high in DECODE state.
REQ-011 Port: seq_err  output  1  Gray sequence violation pulse; present only with GRAY_SEQ_CHECK_EN.

Function
REQ-012 FSM states SHALL be IDLE, DECODE and HOLD.
REQ-013 in_ready SHALL be 1 in IDLE, equal out_ready in HOLD, and 0 in DECODE.
REQ-014 Accept: in_valid&in_ready at an edge SHALL capture gray_in, load bit counter = WIDTH-1, and go to DECODE.
REQ-015 DECODE: each edge SHALL resolve one bit MSB-first, b[WIDTH-1]=g[WIDTH-1] and b[i]=b[i+1]^g[i], then decrement the counter.
REQ-016 The edge resolving bit 0 SHALL load bin_out with the full result, set out_valid=1, and go to HOLD.
REQ-017 Latency SHALL be exactly WIDTH edges from the accepting edge to out_valid high, independent of data.
REQ-018 HOLD: bin_out and out_valid SHALL stay stable until out_valid&out_ready.
REQ-019 HOLD with out_ready=1 and in_valid=0: the edge SHALL clear out_valid and go to IDLE.
REQ-020 HOLD with out_ready=1 and in_valid=1: the edge SHALL complete the output handshake and accept the new word in the same edge, going directly to DECODE; the sustained throughput is one word per WIDTH+1 cycles.
REQ-021 in_valid and gray_in SHALL be ignored in DECODE, and gray_in changes after capture SHALL NOT affect the result.
REQ-022 bin_out SHALL change only on the REQ-016 edge; between results it SHALL hold the last value.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, out_valid=0, bin_out=0, busy=0, counter=0 and seq_err=0, regardless of the clock.
REQ-024 Reset asserted mid-DECODE or in HOLD SHALL discard the word in flight with no output produced.
REQ-025 in_ready SHALL be 1 from reset (IDLE state), and the first accept SHALL be possible on the first edge after rst_n rises.

Configuration
REQ-026 Macro GRAY_SEQ_CHECK_EN defined: the block SHALL keep the last accepted gray word plus a first-word flag cleared by reset.
REQ-027 With GRAY_SEQ_CHECK_EN, each accept after the first SHALL compare gray_in with the previous word and pulse seq_err high for exactly one cycle after the accepting edge when the Hamming distance is not 1 (0 counts as an error).
REQ-028 With GRAY_SEQ_CHECK_EN, seq_err SHALL NOT alter decoding or the handshake.
REQ-029 Macro GRAY_SEQ_CHECK_EN undefined: the seq_err port and all check logic SHALL be absent.

Verification (WIDTH=4)
REQ-030 Accept gray_in=1000, out_ready=1 -> out_valid high 4 edges after accept, bin_out=1111.
REQ-031 All 16 codes back-to-back, in_valid and out_ready held 1 -> each bin_out is the exact inverse Gray (e.g. 0110->0100, 1010->1100), accepts every 5 cycles.
REQ-032 Accept 0011, then hold out_ready=0 for 10 cycles -> out_valid=1, bin_out=0010 stable and in_ready=0 throughout; output handshake on the first cycle out_ready=1.
REQ-033 rst_n pulsed low 2 edges after accepting 1111 -> out_valid=0 and bin_out=0000 immediately; no result appears; in_ready=1 after release.
REQ-034 In HOLD with out_ready=1 and in_valid=1 carrying 0101 -> same-edge handoff, busy=1 next cycle, bin_out=0110 four edges later.
REQ-035 With GRAY_SEQ_CHECK_EN, inputs 0000, 0001, 0011, 0110, 0110 -> seq_err pulses only after the accepts of the first 0110 (distance 2) and the second 0110 (distance 0).
